// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single fixed-latency RAM.
// One access in flight at a time; contention alternates between requesters.
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t     state_r, state_nxt_s;
  logic [2:0] lat_cnt_r, lat_cnt_nxt_s;
  logic       owner_d_r;
  logic       owner_we_r;
  logic       last_d_r;
  logic       win_d_s, win_f_s;
  logic       waited_s;

  // Arbitration: data wins unless fetch is also asking and data won last time
  always_comb begin
    win_d_s = d_req & (~if_req | ~last_d_r);
    win_f_s = if_req & ~win_d_s;
  end

  // Next state, RAM issue strobes and completion pulses; all quiet under reset
  always_comb begin
    state_nxt_s   = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    if_rvalid     = 1'b0;
    d_done        = 1'b0;
    busy          = 1'b0;
    waited_s      = 1'b0;
    if (reset) begin
      case (state_r)
        IDLE: begin
          waited_s = if_req & d_req;
          if (win_d_s) begin
            d_gnt     = 1'b1;
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
          end else if (win_f_s) begin
            if_gnt   = 1'b1;
            ram_en   = 1'b1;
            ram_addr = if_addr;
          end else begin
            ram_en = 1'b0;
          end
          if (win_d_s | win_f_s) begin
            busy          = 1'b1;
            lat_cnt_nxt_s = 3'd1;
            state_nxt_s   = (MEM_LAT > 1) ? WAIT : DONE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WAIT: begin
          busy     = 1'b1;
          waited_s = if_req | d_req;
          if (lat_cnt_r == LAT_LAST) begin
            state_nxt_s = DONE;
          end else begin
            lat_cnt_nxt_s = lat_cnt_r + 3'd1;
          end
        end
        DONE: begin
          busy        = 1'b1;
          waited_s    = if_req | d_req;
          state_nxt_s = IDLE;
          if (owner_d_r) begin
            d_done = 1'b1;
          end else begin
            if_rvalid = 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // State, latency counter and ownership of the in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      lat_cnt_r  <= 3'd0;
      owner_d_r  <= 1'b0;
      owner_we_r <= 1'b0;
      last_d_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      lat_cnt_r <= lat_cnt_nxt_s;
      if (d_gnt | if_gnt) begin
        owner_d_r  <= d_gnt;
        owner_we_r <= d_gnt & d_we;
        last_d_r   <= d_gnt;
      end
    end
  end

  // Read data capture at the end of DONE; writes leave both registers alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state_r == DONE && !owner_we_r) begin
      if (owner_d_r) begin
        d_rdata <= ram_rdata;
      end else begin
        if_rdata <= ram_rdata;
      end
    end
  end

  // Saturating count of cycles where some request had to wait
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= 16'd0;
    end else if (waited_s && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter with MEM_LAT=2 against a
// timeline-based reference model (issue time, completion time, free time).
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, ram_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_done, ram_en, ram_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          cyc, m_free_at, m_done_at;
  bit          m_owner_d, m_we, m_last_d;
  logic [15:0] m_cnt;
  logic [DW-1:0] m_if_rdata, m_d_rdata;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; ram_rdata = 32'h0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_fetch_only;
    do_reset;
    if_req = 1'b1; if_addr = 32'h10; ram_rdata = 32'hAABB;
    sample;
    n_vec++;
    if ({if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, busy} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL fetch_issue: got gnt=%b en=%b we=%b addr=%h busy=%b, expected gnt=1 en=1 we=0 addr=10 busy=1", if_gnt, ram_en, ram_we, ram_addr, busy);
    end
    tick; sample;
    n_vec++;
    if ({if_gnt, if_rvalid, busy} !== 3'b001) begin
      n_err++; $display("FAIL fetch_wait: got gnt/rvalid/busy=%b expected 001", {if_gnt, if_rvalid, busy});
    end
    tick; sample;
    n_vec++;
    if ({if_rvalid, d_done, if_gnt} !== 3'b100) begin
      n_err++; $display("FAIL fetch_done: got rvalid/done/gnt=%b expected 100", {if_rvalid, d_done, if_gnt});
    end
    tick; sample;
    n_vec++;
    if ({if_gnt, if_rdata} !== {1'b1, 32'hAABB}) begin
      n_err++; $display("FAIL fetch_next: got gnt=%b rdata=%h expected gnt=1 rdata=0000aabb", if_gnt, if_rdata);
    end
    if_req = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_reset;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h55; d_wdata = 32'h66;
    reset = 1'b0;
    #2;
    n_vec++;
    if ({if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, if_rvalid, d_done, busy, if_rdata, d_rdata} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got gnt=%b%b en=%b rdata=%h/%h busy=%b expected all 0", if_gnt, d_gnt, ram_en, if_rdata, d_rdata, busy);
    end
    n_vec++;
    if (conflict_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt);
    end
    do_reset;
  endtask

  task automatic test_contention;
    do_reset;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int c = 0; c < 7; c++) begin
      sample;
      n_vec++;
      if ({if_gnt, d_gnt} !== {(c == 3), (c == 0 || c == 6)}) begin
        n_err++; $display("FAIL contention_gnt c=%0d: got if/d=%b%b expected %b%b", c, if_gnt, d_gnt, (c == 3), (c == 0 || c == 6));
      end
      if (c == 3) begin
        n_vec++;
        if (conflict_cnt !== 16'd3) begin
          n_err++; $display("FAIL contention_cnt: got %0d expected 3", conflict_cnt);
        end
      end
      tick;
    end
  endtask

  task automatic test_write;
    do_reset;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; ram_rdata = 32'h1234;
    sample;
    tick;
    d_req = 1'b0;
    tick; sample;
    n_vec++;
    if (d_done !== 1'b1) begin
      n_err++; $display("FAIL read_done: got %b expected 1", d_done);
    end
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h200; ram_rdata = 32'hDEAD;
    sample;
    n_vec++;
    if ({d_gnt, ram_en, ram_we, ram_addr, ram_wdata, d_rdata} !== {1'b1, 1'b1, 1'b1, 32'h14, 32'h200, 32'h1234}) begin
      n_err++; $display("FAIL write_issue: got gnt=%b en=%b we=%b addr=%h wdata=%h rdata=%h expected 1 1 1 14 200 1234", d_gnt, ram_en, ram_we, ram_addr, ram_wdata, d_rdata);
    end
    tick;
    d_req = 1'b0; d_we = 1'b0;
    tick; sample;
    n_vec++;
    if ({d_done, if_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL write_done: got done/rvalid=%b expected 10", {d_done, if_rvalid});
    end
    tick; sample;
    n_vec++;
    if (d_rdata !== 32'h1234) begin
      n_err++; $display("FAIL write_rdata_hold: got %h expected 00001234", d_rdata);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    if_req = 1'b1; if_addr = 32'h40; ram_rdata = 32'h5555;
    sample;
    n_vec++;
    if (if_gnt !== 1'b1) begin
      n_err++; $display("FAIL abort_issue: got %b expected 1", if_gnt);
    end
    tick;
    if_req = 1'b0;
    sample;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, if_rvalid, d_done, busy, if_rdata, d_rdata, conflict_cnt} !== '0) begin
      n_err++; $display("FAIL abort_outputs: got busy=%b rvalid=%b en=%b expected all 0", busy, if_rvalid, ram_en);
    end
    tick; tick; sample;
    n_vec++;
    if ({if_rvalid, if_rdata} !== 33'h0) begin
      n_err++; $display("FAIL abort_no_rvalid: got rvalid=%b rdata=%h expected 0", if_rvalid, if_rdata);
    end
    tick;
    reset = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    sample;
    n_vec++;
    if ({d_gnt, ram_en, ram_addr} !== {1'b1, 1'b1, 32'h80}) begin
      n_err++; $display("FAIL abort_regrant: got gnt=%b en=%b addr=%h expected 1 1 80", d_gnt, ram_en, ram_addr);
    end
    tick;
    d_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_withdrawn;
    do_reset;
    d_req = 1'b1; d_we = 1'b0;
    sample;
    tick;
    d_req = 1'b0; if_req = 1'b1;
    sample;
    n_vec++;
    if (if_gnt !== 1'b0) begin
      n_err++; $display("FAIL withdrawn_wait_gnt: got %b expected 0", if_gnt);
    end
    tick;
    if_req = 1'b0;
    sample;
    n_vec++;
    if ({if_gnt, conflict_cnt} !== {1'b0, 16'd1}) begin
      n_err++; $display("FAIL withdrawn_cnt: got gnt=%b cnt=%0d expected gnt=0 cnt=1", if_gnt, conflict_cnt);
    end
    tick; sample;
    n_vec++;
    if ({if_gnt, ram_en, conflict_cnt} !== {2'b00, 16'd1}) begin
      n_err++; $display("FAIL withdrawn_idle: got gnt=%b en=%b cnt=%0d expected 0 0 1", if_gnt, ram_en, conflict_cnt);
    end
  endtask

  task automatic test_random;
    logic [70:0] exp_comb;
    logic        waited, idle, win_d, win_f;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    do_reset;
    cyc = 0; m_free_at = 0; m_done_at = -1; m_last_d = 1'b0; m_owner_d = 1'b0; m_we = 1'b0;
    m_cnt = 16'd0; m_if_rdata = '0; m_d_rdata = '0;
    for (int i = 0; i < 600; i++) begin
      if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; ram_rdata = $urandom;
      idle = (cyc >= m_free_at);
      win_d = idle && d_req && (!if_req || !m_last_d);
      win_f = idle && if_req && !win_d;
      e_addr = '0; e_wdata = '0;
      if (win_d || win_f) begin
        m_done_at = cyc + LAT; m_free_at = cyc + LAT + 1;
        m_owner_d = win_d; m_we = win_d && d_we; m_last_d = win_d;
        e_addr = win_d ? d_addr : if_addr;
        e_wdata = win_d ? d_wdata : 32'h0;
      end
      waited = idle ? (if_req && d_req) : (if_req || d_req);
      exp_comb = {win_f, win_d, (win_d || win_f), (win_d && d_we), e_addr, e_wdata,
                  (cyc == m_done_at && !m_owner_d), (cyc == m_done_at && m_owner_d), (cyc < m_free_at)};
      sample;
      n_vec++;
      if ({if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, if_rvalid, d_done, busy} !== exp_comb) begin
        n_err++; $display("FAIL random_comb cyc=%0d: got %h expected %h", cyc, {if_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_wdata, if_rvalid, d_done, busy}, exp_comb);
      end
      n_vec++;
      if ({if_rdata, d_rdata, conflict_cnt} !== {m_if_rdata, m_d_rdata, m_cnt}) begin
        n_err++; $display("FAIL random_regs cyc=%0d: got %h/%h/%h expected %h/%h/%h", cyc, if_rdata, d_rdata, conflict_cnt, m_if_rdata, m_d_rdata, m_cnt);
      end
      if (waited && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (cyc == m_done_at && !m_we) begin
        if (m_owner_d) m_d_rdata = ram_rdata;
        else m_if_rdata = ram_rdata;
      end
      cyc++;
      tick;
    end
  endtask

  task automatic test_saturation;
    do_reset;
    if_req = 1'b1; d_req = 1'b1;
    repeat (70000) @(posedge clk);
    sample;
    n_vec++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_reach: got %h expected ffff", conflict_cnt);
    end
    repeat (10) @(posedge clk);
    sample;
    n_vec++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt);
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    do_reset;
    test_fetch_only;
    test_reset;
    test_contention;
    test_write;
    test_reset_mid;
    test_withdrawn;
    test_random;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
